// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared types and defaults for the tv80s req/ack bus bridge
package z80_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] IO_PAGE_DEFAULT     = 8'h10;
  localparam logic [7:0] INTA_VECTOR_DEFAULT = 8'hFF;
  localparam int         WAIT_LIMIT_DEFAULT  = 16;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        io;
  } bus_cmd_t;

endpackage

// File: rtl/z80_bus_bridge.sv
// rtl/z80_bus_bridge.sv - tv80s strobe bus to synchronous req/ack memory port bridge
module z80_bus_bridge
  import z80_bus_pkg::*;
#(
  parameter logic [7:0] IO_PAGE     = IO_PAGE_DEFAULT,
  parameter logic [7:0] INTA_VECTOR = INTA_VECTOR_DEFAULT,
  parameter int         WAIT_LIMIT  = WAIT_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  input  logic        cpu_rfsh_n,
  output logic        cpu_wait_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_io,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  localparam int               CNT_W    = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  state_t           state, state_nx;
  bus_cmd_t         cmd_q, cmd_nx;
  logic             req_q, req_nx;
  logic [7:0]       rdata_q, rdata_nx;
  logic             err_q, err_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;

  logic active, inta, strobes;

  assign active  = cpu_rfsh_n & (~cpu_mreq_n | ~cpu_iorq_n) & (~cpu_rd_n | ~cpu_wr_n);
  assign inta    = ~cpu_m1_n & ~cpu_iorq_n;
  assign strobes = active | inta;

  // Combinational so the CPU sees wait in the same cycle its strobe appears.
  assign cpu_wait_n = ~(strobes && (state != DONE));

  assign cpu_di    = rdata_q;
  assign mem_req   = req_q;
  assign mem_we    = cmd_q.we;
  assign mem_io    = cmd_q.io;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign bus_err   = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cmd_q   <= '0;
      req_q   <= 1'b0;
      rdata_q <= 8'hFF;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      cmd_q   <= cmd_nx;
      req_q   <= req_nx;
      rdata_q <= rdata_nx;
      err_q   <= err_nx;
      cnt_q   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cmd_nx   = cmd_q;
    req_nx   = req_q;
    rdata_nx = rdata_q;
    err_nx   = err_q;
    cnt_nx   = cnt_q;

    case (state)
      IDLE: begin
        if (inta) begin
          rdata_nx = INTA_VECTOR;
          state_nx = DONE;
        end else if (active) begin
          cmd_nx.addr  = ~cpu_iorq_n ? {IO_PAGE, cpu_a[7:0]} : cpu_a;
          cmd_nx.io    = ~cpu_iorq_n;
          cmd_nx.we    = ~cpu_wr_n;
          cmd_nx.wdata = cpu_dout;
          req_nx       = 1'b1;
          cnt_nx       = '0;
          state_nx     = REQ;
        end
      end

      REQ: begin
        // A late ack wins over the timeout firing in the same cycle.
        if (mem_ack) begin
          req_nx = 1'b0;
          if (!cmd_q.we) begin
            rdata_nx = mem_rdata;
          end
          state_nx = strobes ? DONE : IDLE;
        end else if (!strobes) begin
          state_nx = DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          req_nx   = 1'b0;
          rdata_nx = 8'hFF;
          err_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end

      // The CPU has left; keep req up until the memory side finishes.
      DRAIN: begin
        if (mem_ack) begin
          req_nx   = 1'b0;
          state_nx = IDLE;
        end
      end

      DONE: begin
        if (!strobes) begin
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// tb/tb_z80_bus_bridge.sv - self-checking bench for z80_bus_bridge
module tb_z80_bus_bridge;
  import z80_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_di;
  logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n;
  logic        cpu_wait_n;
  logic        mem_req, mem_we, mem_io;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:65535];
  bus_cmd_t   exp_q [$];
  int         ack_lat   = 1;
  int         req_cycles = 0;
  int         req_count = 0;

  always #5 clk = ~clk;

  z80_bus_bridge dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_a      (cpu_a),
    .cpu_dout   (cpu_dout),
    .cpu_di     (cpu_di),
    .cpu_mreq_n (cpu_mreq_n),
    .cpu_iorq_n (cpu_iorq_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_m1_n   (cpu_m1_n),
    .cpu_rfsh_n (cpu_rfsh_n),
    .cpu_wait_n (cpu_wait_n),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_io     (mem_io),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .bus_err    (bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: ack after ack_lat cycles of req (0 = never); scoreboard popped on each new request.
  always @(posedge clk) begin
    #2;
    mem_ack = 1'b0;
    if (mem_req) begin
      req_cycles++;
      if (req_cycles == 1) begin
        req_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_req", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          bus_cmd_t e;
          e = exp_q.pop_front();
          check("req_addr", 32'(mem_addr), 32'(e.addr));
          check("req_we", 32'(mem_we), 32'(e.we));
          check("req_io", 32'(mem_io), 32'(e.io));
          if (e.we) check("req_wdata", 32'(mem_wdata), 32'(e.wdata));
        end
      end
      if (ack_lat != 0 && req_cycles == ack_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
      end
    end else begin
      req_cycles = 0;
    end
  end

  task automatic idle_strobes();
    cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1;
    cpu_wr_n   = 1'b1; cpu_m1_n   = 1'b1; cpu_rfsh_n = 1'b1;
  endtask

  // Holds the strobes until wait releases (bounded), captures cpu_di, then ends the cycle.
  task automatic run_cycle(input logic [15:0] a, input logic [7:0] d,
                           input logic mreq_n, input logic iorq_n, input logic rd_n,
                           input logic wr_n, input logic m1_n, input logic rfsh_n,
                           input int lat, output int waits, output logic [7:0] di);
    ack_lat = lat;
    @(negedge clk);
    cpu_a = a; cpu_dout = d;
    cpu_mreq_n = mreq_n; cpu_iorq_n = iorq_n; cpu_rd_n = rd_n;
    cpu_wr_n = wr_n; cpu_m1_n = m1_n; cpu_rfsh_n = rfsh_n;
    waits = 0;
    #1;
    while (!cpu_wait_n && waits < 40) begin
      waits++;
      @(negedge clk); #1;
    end
    di = cpu_di;
    @(negedge clk);
    idle_strobes();
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [7:0]  d;
    logic        io;
    logic        wr;
    int          lat;
    int          exp_waits;
    logic [7:0]  exp_di;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int         waits;
    int         rc;
    logic [7:0] di;
    bus_cmd_t   e;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h470C] = 8'h82;
    mem[16'h1034] = 8'hC3;
    mem[16'h0000] = 8'h35;
    mem[16'h10CD] = 8'h77;
    mem[16'h2000] = 8'hA5;
    mem[16'h3000] = 8'h5C;

    vecs[0] = '{"rd_470C",     16'h470C, 8'h00, 1'b0, 1'b0, 2,  3,  8'h82, 16'h470C};
    vecs[1] = '{"wr_470C",     16'h470C, 8'h81, 1'b0, 1'b1, 2,  3,  8'h82, 16'h470C};
    vecs[2] = '{"rd_back",     16'h470C, 8'h00, 1'b0, 1'b0, 1,  2,  8'h81, 16'h470C};
    vecs[3] = '{"out_34",      16'h0034, 8'h5A, 1'b1, 1'b1, 1,  2,  8'h81, 16'h1034};
    vecs[4] = '{"in_34",       16'h0034, 8'h00, 1'b1, 1'b0, 3,  4,  8'h5A, 16'h1034};
    vecs[5] = '{"rd_0000",     16'h0000, 8'h00, 1'b0, 1'b0, 4,  5,  8'h35, 16'h0000};
    vecs[6] = '{"in_ABCD",     16'hABCD, 8'h00, 1'b1, 1'b0, 1,  2,  8'h77, 16'h10CD};
    vecs[7] = '{"rd_last_ack", 16'h2000, 8'h00, 1'b0, 1'b0, 16, 17, 8'hA5, 16'h2000};

    mem_ack = 1'b0; mem_rdata = 8'h00;
    cpu_a = 16'h0000; cpu_dout = 8'h00;
    idle_strobes();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_io", 32'(mem_io), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_cpu_di", 32'(cpu_di), 32'hFF);
    check("rst_bus_err", 32'(bus_err), 0);
    check("rst_wait_n", 32'(cpu_wait_n), 1);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      e.addr = vecs[i].exp_addr; e.wdata = vecs[i].d; e.we = vecs[i].wr; e.io = vecs[i].io;
      exp_q.push_back(e);
      rc = req_count;
      run_cycle(vecs[i].a, vecs[i].d, vecs[i].io, ~vecs[i].io, vecs[i].wr, ~vecs[i].wr,
                1'b1, 1'b1, vecs[i].lat, waits, di);
      check({vecs[i].name, "_waits"}, 32'(waits), 32'(vecs[i].exp_waits));
      check({vecs[i].name, "_di"}, 32'(di), 32'(vecs[i].exp_di));
      check({vecs[i].name, "_reqs"}, 32'(req_count - rc), 1);
      check({vecs[i].name, "_err"}, 32'(bus_err), 0);
      check({vecs[i].name, "_sb_empty"}, 32'(exp_q.size()), 0);
    end

    // Strobes vanish mid-REQ: req stays up until ack, the read data is thrown away.
    e.addr = 16'h3000; e.wdata = 8'h00; e.we = 1'b0; e.io = 1'b0;
    exp_q.push_back(e);
    rc = req_count;
    ack_lat = 3;
    @(negedge clk);
    cpu_a = 16'h3000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    #1 check("drain_wait_idle", 32'(cpu_wait_n), 0);
    @(negedge clk);
    #1 check("drain_req_up", 32'(mem_req), 1);
    idle_strobes();
    #1 check("drain_wait_released", 32'(cpu_wait_n), 1);
    @(negedge clk);
    #1 check("drain_req_held", 32'(mem_req), 1);
    repeat (2) @(negedge clk);
    #1 check("drain_req_dropped", 32'(mem_req), 0);
    check("drain_di_kept", 32'(cpu_di), 32'hA5);
    check("drain_reqs", 32'(req_count - rc), 1);

    rc = req_count;
    run_cycle(16'h00FF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, waits, di);
    check("inta_waits", 32'(waits), 1);
    check("inta_di", 32'(di), 32'hFF);
    check("inta_reqs", 32'(req_count - rc), 0);

    rc = req_count;
    run_cycle(16'h0055, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, waits, di);
    check("rfsh_waits", 32'(waits), 0);
    check("rfsh_reqs", 32'(req_count - rc), 0);

    e.addr = 16'h2000; e.wdata = 8'h00; e.we = 1'b0; e.io = 1'b0;
    exp_q.push_back(e);
    run_cycle(16'h2000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, waits, di);
    check("tmo_waits", 32'(waits), 17);
    check("tmo_di", 32'(di), 32'hFF);
    check("tmo_err", 32'(bus_err), 1);
    check("tmo_req_low", 32'(mem_req), 0);

    e.addr = 16'h0000; exp_q.push_back(e);
    run_cycle(16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, waits, di);
    check("sticky_di", 32'(di), 32'h35);
    check("sticky_err", 32'(bus_err), 1);

    // Asynchronous reset while a request is outstanding.
    e.addr = 16'h470C; exp_q.push_back(e);
    ack_lat = 0;
    @(negedge clk);
    cpu_a = 16'h470C; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_req_up", 32'(mem_req), 1);
    reset_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 0);
    check("arst_mem_addr", 32'(mem_addr), 0);
    check("arst_cpu_di", 32'(cpu_di), 32'hFF);
    check("arst_bus_err", 32'(bus_err), 0);
    idle_strobes();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_req", 32'(mem_req), 0);
    check("final_sb_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
